// File: rtl/pht_pkg.sv
// pht_pkg: shared widths, FSM states and counter arithmetic for the PHT controller
package pht_pkg;
   localparam int PHT_IDX_W = 5;
   localparam int PHT_CTR_W = 2;
   localparam logic [PHT_CTR_W-1:0] INIT_CTR = 2'b01;
   typedef enum logic {INIT, RUN} pht_state_e;
   function automatic logic [PHT_CTR_W-1:0] sat_upd(input logic [PHT_CTR_W-1:0] ctr, input logic taken);
      sat_upd = taken ? ((ctr == '1) ? ctr : ctr + 1'b1) : ((ctr == '0) ? ctr : ctr - 1'b1);
   endfunction
endpackage

// File: rtl/pht_ctr_ctrl_ram.sv
// qpram_32x2: 32x2 LUTRAM, three async read ports and one sync write port, no reset
module qpram_32x2
   import pht_pkg::*;
(
   input  logic                 clk,
   input  logic                 cen_i,
   input  logic                 wen_i,
   input  logic [PHT_IDX_W-1:0] aw_i,
   input  logic [PHT_CTR_W-1:0] di_i,
   input  logic [PHT_IDX_W-1:0] a0_i,
   input  logic [PHT_IDX_W-1:0] a1_i,
   input  logic [PHT_IDX_W-1:0] a2_i,
   output logic [PHT_CTR_W-1:0] do0_o,
   output logic [PHT_CTR_W-1:0] do1_o,
   output logic [PHT_CTR_W-1:0] do2_o
);
   logic [PHT_CTR_W-1:0] mem_q [2**PHT_IDX_W];
   // single write port; reads see the pre-write value during the write cycle
   always_ff @(posedge clk)
      if (cen_i && wen_i) mem_q[aw_i] <= di_i;
   assign do0_o = mem_q[a0_i];
   assign do1_o = mem_q[a1_i];
   assign do2_o = mem_q[a2_i];
endmodule

// File: rtl/pht_ctr_ctrl.sv
// pht_ctr_ctrl: clears the counter table, arbitrates two updaters and serves three lookups
module pht_ctr_ctrl
   import pht_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_i,
   output logic                 init_busy_o,
   input  logic [PHT_IDX_W-1:0] lk_idx0_i,
   input  logic [PHT_IDX_W-1:0] lk_idx1_i,
   input  logic [PHT_IDX_W-1:0] lk_idx2_i,
   output logic [PHT_CTR_W-1:0] lk_ctr0_o,
   output logic [PHT_CTR_W-1:0] lk_ctr1_o,
   output logic [PHT_CTR_W-1:0] lk_ctr2_o,
   input  logic [1:0]           up_valid_i,
   output logic [1:0]           up_ready_o,
   input  logic [PHT_IDX_W-1:0] up_idx0_i,
   input  logic [PHT_IDX_W-1:0] up_idx1_i,
   input  logic [1:0]           up_taken_i,
   input  logic [PHT_CTR_W-1:0] up_ctr0_i,
   input  logic [PHT_CTR_W-1:0] up_ctr1_i
);
   pht_state_e           state_q, state_d;
   logic [PHT_IDX_W-1:0] sweep_q, sweep_d;
   logic                 rr_q, rr_d;
   logic                 s1_v_q, s1_v_d;
   logic [PHT_IDX_W-1:0] s1_idx_q, s1_idx_d;
   logic                 s1_tk_q, s1_tk_d;
   logic [PHT_CTR_W-1:0] s1_base_q, s1_base_d;
   logic [PHT_CTR_W-1:0] s1_new, sel_ctr, di, rd0, rd1, rd2;
   logic [PHT_IDX_W-1:0] sel_idx, aw;
   logic [1:0]           gnt;
   logic                 run, we;
   assign s1_new = sat_upd(s1_base_q, s1_tk_q);
   // grant, next state and write-port mux; clear overrides any grant or pending write
   always_comb begin
      run       = state_q == RUN;
      gnt       = (run && !clr_i) ? ((up_valid_i == 2'b11) ? (rr_q ? 2'b10 : 2'b01) : up_valid_i) : 2'b00;
      sel_idx   = gnt[1] ? up_idx1_i : up_idx0_i;
      sel_ctr   = gnt[1] ? up_ctr1_i : up_ctr0_i;
      state_d   = clr_i ? INIT : (!run && sweep_q == '1) ? RUN : state_q;
      sweep_d   = (clr_i || run) ? '0 : sweep_q + 1'b1;
      rr_d      = |gnt ? gnt[0] : rr_q;
      s1_v_d    = |gnt;
      s1_idx_d  = sel_idx;
      s1_tk_d   = gnt[1] ? up_taken_i[1] : up_taken_i[0];
      s1_base_d = (s1_v_q && s1_idx_q == sel_idx) ? s1_new : sel_ctr;
      we        = run ? (s1_v_q && !clr_i) : 1'b1;
      aw        = run ? s1_idx_q : sweep_q;
      di        = run ? s1_new : INIT_CTR;
   end
   // state, sweep pointer, round-robin pointer and S1 update stage
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= INIT;
         sweep_q   <= '0;
         rr_q      <= 1'b0;
         s1_v_q    <= 1'b0;
         s1_idx_q  <= '0;
         s1_tk_q   <= 1'b0;
         s1_base_q <= '0;
      end else begin
         state_q   <= state_d;
         sweep_q   <= sweep_d;
         rr_q      <= rr_d;
         s1_v_q    <= s1_v_d;
         s1_idx_q  <= s1_idx_d;
         s1_tk_q   <= s1_tk_d;
         s1_base_q <= s1_base_d;
      end
   end
   qpram_32x2 u_ram (
      .clk   (clk),
      .cen_i (1'b1),
      .wen_i (we),
      .aw_i  (aw),
      .di_i  (di),
      .a0_i  (lk_idx0_i),
      .a1_i  (lk_idx1_i),
      .a2_i  (lk_idx2_i),
      .do0_o (rd0),
      .do1_o (rd1),
      .do2_o (rd2)
   );
   assign up_ready_o  = gnt;
   assign init_busy_o = !run;
   assign lk_ctr0_o   = run ? rd0 : INIT_CTR;
   assign lk_ctr1_o   = run ? rd1 : INIT_CTR;
   assign lk_ctr2_o   = run ? rd2 : INIT_CTR;
endmodule

// File: tb/tb_pht_ctr_ctrl.sv
// tb_pht_ctr_ctrl: scoreboard bench for the PHT counter controller
module tb_pht_ctr_ctrl;
   import pht_pkg::*;
   logic       clk = 1'b0;
   logic       rst, clr, busy, pr;
   logic [4:0] lk0, lk1, lk2, ui0, ui1;
   logic [1:0] lc0, lc1, lc2, uv, ur, ut, uc0, uc1, hs;
   int         total = 0;
   int         bad = 0;
   typedef struct {string nm; bit cs; logic b; logic [1:0] r; bit cl; logic [1:0] e0, e1, e2;} probe_t;
   typedef struct {string nm; logic [31:0] code;} gnt_t;
   probe_t pq[$];
   gnt_t   gq[$];
   probe_t p;
   gnt_t   g;

   pht_ctr_ctrl dut (
      .clk(clk), .rst(rst), .clr_i(clr), .init_busy_o(busy),
      .lk_idx0_i(lk0), .lk_idx1_i(lk1), .lk_idx2_i(lk2),
      .lk_ctr0_o(lc0), .lk_ctr1_o(lc1), .lk_ctr2_o(lc2),
      .up_valid_i(uv), .up_ready_o(ur), .up_idx0_i(ui0), .up_idx1_i(ui1),
      .up_taken_i(ut), .up_ctr0_i(uc0), .up_ctr1_i(uc1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // monitor: pop expected grants on every handshake and expected outputs on every probe
   always @(negedge clk) begin
      hs = uv & ur;
      if (hs != 2'b00) begin
         if (gq.size() == 0) chk("unexpected_grant", {30'b0, hs}, 32'd0);
         else begin
            g = gq.pop_front();
            chk(g.nm, {25'b0, hs, hs[1] ? ui1 : ui0}, g.code);
         end
      end
      if (pr) begin
         if (pq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL probe_underflow: got none expected entry");
         end else begin
            p = pq.pop_front();
            if (p.cs) begin
               chk({p.nm, "_busy"}, {31'b0, busy}, {31'b0, p.b});
               chk({p.nm, "_ready"}, {30'b0, ur}, {30'b0, p.r});
            end
            if (p.cl) begin
               chk({p.nm, "_lk0"}, {30'b0, lc0}, {30'b0, p.e0});
               chk({p.nm, "_lk1"}, {30'b0, lc1}, {30'b0, p.e1});
               chk({p.nm, "_lk2"}, {30'b0, lc2}, {30'b0, p.e2});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      pr = 1'b0;
   endtask

   task automatic probe(input string nm, input bit cs, input logic b, input logic [1:0] r,
                        input bit cl, input logic [1:0] e0, input logic [1:0] e1, input logic [1:0] e2);
      pq.push_back('{nm, cs, b, r, cl, e0, e1, e2});
      pr = 1'b1;
   endtask

   task automatic lkv(input string nm, input logic [1:0] e0, input logic [1:0] e1, input logic [1:0] e2);
      probe(nm, 1'b0, 1'b0, 2'b00, 1'b1, e0, e1, e2);
   endtask

   task automatic exp_gnt(input string nm, input bit port, input logic [4:0] idx);
      gq.push_back('{nm, {25'b0, port ? 2'b10 : 2'b01, idx}});
   endtask

   task automatic upd(input bit port, input logic [4:0] idx, input logic tk, input logic [1:0] c);
      if (port) begin
         ui1 = idx; ut[1] = tk; uc1 = c;
      end else begin
         ui0 = idx; ut[0] = tk; uc0 = c;
      end
   endtask

   task automatic lk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
      lk0 = a; lk1 = b; lk2 = c;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; pr = 1'b0; uv = 2'b11; ut = 2'b00;
      ui0 = 5'd0; ui1 = 5'd1; uc0 = 2'b00; uc1 = 2'b00;
      lk(5'd0, 5'd0, 5'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         lk(5'(i), 5'(31 - i), 5'(i));
         probe($sformatf("sweep%0d", i), 1'b1, 1'b1, 2'b00, 1'b1, INIT_CTR, INIT_CTR, INIT_CTR);
         step();
      end
      uv = 2'b00;
      probe("sweep_done", 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
      step();
      for (int i = 0; i < 32; i++) begin
         lk(5'(i), 5'(31 - i), 5'((i + 13) % 32));
         lkv($sformatf("readback%0d", i), 2'b01, 2'b01, 2'b01);
         step();
      end
      lk(5'd5, 5'd5, 5'd5);
      upd(1'b0, 5'd5, 1'b1, 2'b01); uv = 2'b01;
      exp_gnt("single_gnt", 1'b0, 5'd5);
      lkv("single_hs", 2'b01, 2'b01, 2'b01);
      step();
      uv = 2'b00;
      lkv("single_n", 2'b01, 2'b01, 2'b01);
      step();
      lkv("single_n1", 2'b10, 2'b10, 2'b10);
      step();
      upd(1'b0, 5'd8, 1'b0, 2'b00); uv = 2'b01;
      exp_gnt("sat_lo_gnt", 1'b0, 5'd8);
      step();
      upd(1'b1, 5'd7, 1'b1, 2'b11); uv = 2'b10;
      exp_gnt("sat_hi_gnt", 1'b1, 5'd7);
      step();
      uv = 2'b00;
      step();
      lk(5'd7, 5'd8, 5'd5);
      lkv("sat", 2'b11, 2'b00, 2'b10);
      step();
      upd(1'b0, 5'd10, 1'b1, 2'b01); upd(1'b1, 5'd11, 1'b1, 2'b01); uv = 2'b11;
      exp_gnt("rr0", 1'b0, 5'd10);
      step();
      upd(1'b0, 5'd12, 1'b0, 2'b11);
      exp_gnt("rr1", 1'b1, 5'd11);
      step();
      upd(1'b1, 5'd13, 1'b1, 2'b10);
      exp_gnt("rr2", 1'b0, 5'd12);
      step();
      upd(1'b0, 5'd14, 1'b1, 2'b10);
      exp_gnt("rr3", 1'b1, 5'd13);
      step();
      uv = 2'b01;
      exp_gnt("rr4", 1'b0, 5'd14);
      step();
      uv = 2'b00;
      step();
      lk(5'd10, 5'd11, 5'd12);
      lkv("cont_a", 2'b10, 2'b10, 2'b10);
      step();
      lk(5'd13, 5'd14, 5'd5);
      lkv("cont_b", 2'b11, 2'b11, 2'b10);
      step();
      lk(5'd9, 5'd9, 5'd9);
      upd(1'b0, 5'd9, 1'b1, 2'b01); uv = 2'b01;
      exp_gnt("b2b_a", 1'b0, 5'd9);
      lkv("b2b_0", 2'b01, 2'b01, 2'b01);
      step();
      exp_gnt("b2b_b", 1'b0, 5'd9);
      lkv("b2b_1", 2'b01, 2'b01, 2'b01);
      step();
      uv = 2'b00;
      lkv("b2b_2", 2'b10, 2'b10, 2'b10);
      step();
      lkv("b2b_3", 2'b11, 2'b11, 2'b11);
      step();
      upd(1'b0, 5'd3, 1'b1, 2'b01); uv = 2'b01;
      exp_gnt("clr_upd", 1'b0, 5'd3);
      step();
      upd(1'b1, 5'd20, 1'b1, 2'b01); uv = 2'b10; clr = 1'b1;
      probe("clr_cycle", 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
      step();
      clr = 1'b0; uv = 2'b00;
      lk(5'd3, 5'd20, 5'd9);
      for (int i = 0; i < 32; i++) begin
         probe($sformatf("resweep%0d", i), 1'b1, 1'b1, 2'b00, 1'b1, INIT_CTR, INIT_CTR, INIT_CTR);
         step();
      end
      probe("resweep_done", 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 2'b01, 2'b01);
      step();
      for (int i = 0; i < 10 && pq.size() != 0; i++) step();
      chk("probes_pending", pq.size(), 32'd0);
      chk("grants_pending", gq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
